// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single-cycle ALU: accept one op, drive the ALU
// from registers for one cycle, then hold the result until the granted port takes it.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in1,
    input  logic [DATA_W-1:0] req0_in2,
    input  logic [OP_W-1:0]   req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in1,
    input  logic [DATA_W-1:0] req1_in2,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,

    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [OP_W-1:0]   alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,

    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic              grant, last_grant, win, accept, rsp_hs;
    logic [DATA_W-1:0] result_reg;
    logic              zero_reg;

    // Winner selection; only meaningful when at least one port is valid.
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid)
            win = RR_EN ? ~last_grant : 1'b0;
        else
            win = req1_valid;
    end

    assign accept = (state == IDLE) && rst_n && (req0_valid || req1_valid);
    assign rsp_hs = (state == RESP) && (grant ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && !win;
        req1_ready = accept && win;
        rsp0_valid = (state == RESP) && !grant;
        rsp1_valid = (state == RESP) && grant;
        busy       = (state != IDLE);
    end

    // Both ports see the same result regs; only the granted port's valid qualifies them.
    assign rsp0_result = result_reg;
    assign rsp0_zero   = zero_reg;
    assign rsp1_result = result_reg;
    assign rsp1_zero   = zero_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_control <= '0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
        end else begin
            if (accept) begin
                alu_in1     <= win ? req1_in1 : req0_in1;
                alu_in2     <= win ? req1_in2 : req0_in2;
                alu_control <= win ? req1_op  : req0_op;
                grant       <= win;
            end
            if (state == EXEC) begin
                result_reg <= alu_result;
                zero_reg   <= alu_zero;
            end
            if (rsp_hs)
                last_grant <= grant;
        end
    end

endmodule
